// File: rtl/conv_rd_dma_scheduler_pkg.sv
// Shared types, constants and burst sizing for the conv read DMA scheduler.
// Latency: n/a (package only).
// Backpressure: n/a. Contents: beat-byte constant, FSM enums, requester indices, burst_len().
package conv_rd_dma_scheduler_pkg;

  localparam int DEF_DATA_W = 256;
  localparam int DEF_BB     = DEF_DATA_W / 8;
  localparam int PAGE_BYTES = 4096;

  // Requester indices, also used as the "last granted" marker of the arbiter
  localparam logic REQ_DAT = 1'b0;
  localparam logic REQ_WT  = 1'b1;

  typedef enum logic {
    AR_IDLE,
    AR_BUSY
  } ar_state_t;

  typedef enum logic [1:0] {
    SPL_IDLE,
    SPL_ISSUE,
    SPL_DRAIN
  } spl_state_t;

  // Beats in the next burst: limited by what is left, the max burst and the
  // room before the next 4KB page boundary (addr_lo is beat aligned).
  function automatic int burst_len(input int beats_left, input int max_burst,
                                   input int addr_lo, input int bb);
    int blen;
    int room;
    room = (PAGE_BYTES - addr_lo) / bb;
    blen = beats_left;
    if (max_burst < blen) blen = max_burst;
    if (room < blen) blen = room;
    return blen;
  endfunction

endpackage

// File: rtl/conv_rd_burst_splitter.sv
// Per-requester command splitter: turns a byte-length read into AXI INCR bursts.
// Latency: burst request visible the cycle after the command handshake.
// Backpressure: cmd_ready only in IDLE; requests pause while MAX_OUTST bursts are in flight.
// Ports: cmd_* command in; req/req_addr/req_blen burst request to arbiter;
//        ar_fire/r_fire/r_last_fire handshake strobes back in; rd_last for the read port.
module conv_rd_burst_splitter
  import conv_rd_dma_scheduler_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 24,
  parameter int BB        = DEF_BB,
  parameter int MAX_BURST = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_bytes,
  output logic              req,
  output logic [ADDR_W-1:0] req_addr,
  output logic [8:0]        req_blen,
  input  logic              ar_fire,
  input  logic              r_fire,
  input  logic              r_last_fire,
  output logic              rd_last
);

  localparam int OFS_W = $clog2(BB);
  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  spl_state_t        state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  beats_left;
  logic [LEN_W-1:0]  ret_left;
  logic [OUT_W-1:0]  outst;
  logic [LEN_W-1:0]  cmd_beats;
  logic [ADDR_W-1:0] cmd_addr_al;

  assign cmd_beats   = cmd_bytes >> OFS_W;
  assign cmd_addr_al = cmd_addr & ~ADDR_W'(BB - 1);
  assign req_addr    = addr;
  assign req_blen    = 9'(burst_len(int'(beats_left), MAX_BURST, int'(addr[11:0]), BB));
  assign rd_last     = (ret_left == LEN_W'(1));

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    req       = 1'b0;
    case (state)
      SPL_IDLE: begin
        cmd_ready = 1'b1;
        // A zero-beat command is consumed without leaving IDLE
        if (cmd_valid && (cmd_beats != '0)) state_nx = SPL_ISSUE;
      end
      SPL_ISSUE: begin
        req = (beats_left != '0) && (outst < OUT_W'(MAX_OUTST));
        if (beats_left == '0) state_nx = SPL_DRAIN;
      end
      SPL_DRAIN: begin
        if (ret_left == '0) state_nx = SPL_IDLE;
      end
      default: state_nx = SPL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SPL_IDLE;
      addr       <= '0;
      beats_left <= '0;
      ret_left   <= '0;
      outst      <= '0;
    end else begin
      state <= state_nx;
      // addr/beats_left hold still while the arbiter presents our burst,
      // so req_blen at the handshake equals the length that was granted
      if (ar_fire) begin
        addr       <= addr + (ADDR_W'(req_blen) << OFS_W);
        beats_left <= beats_left - LEN_W'(req_blen);
      end
      if (r_fire && (ret_left != '0)) ret_left <= ret_left - LEN_W'(1);
      if (ar_fire && !r_last_fire) begin
        outst <= outst + OUT_W'(1);
      end else if (!ar_fire && r_last_fire && (outst != '0)) begin
        outst <= outst - OUT_W'(1);
      end
      if ((state == SPL_IDLE) && cmd_valid) begin
        addr       <= cmd_addr_al;
        beats_left <= cmd_beats;
        ret_left   <= cmd_beats;
      end
    end
  end

endmodule

// File: rtl/conv_rd_dma_scheduler.sv
// Shares one AXI AR/R channel pair between the feature-data and weight fetchers.
// Latency: AR valid one cycle after a grant; R beats routed combinationally by RID.
// Backpressure: AR payload held until ARREADY; RREADY follows the addressed port's rd_ready.
// Ports: dat_cmd_*/dat_rd_* and wt_cmd_*/wt_rd_* requester sides; M_AXI_AR*/M_AXI_R* master;
//        rid_err sticky flag for beats carrying an unknown RID.
module conv_rd_dma_scheduler
  import conv_rd_dma_scheduler_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 24,
  parameter int MAX_BURST = 16,
  parameter int MAX_OUTST = 4,
  parameter int DAT_ID    = 0,
  parameter int WT_ID     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dat_cmd_valid,
  output logic              dat_cmd_ready,
  input  logic [ADDR_W-1:0] dat_cmd_addr,
  input  logic [LEN_W-1:0]  dat_cmd_bytes,
  output logic              dat_rd_valid,
  input  logic              dat_rd_ready,
  output logic [DATA_W-1:0] dat_rd_data,
  output logic              dat_rd_last,
  input  logic              wt_cmd_valid,
  output logic              wt_cmd_ready,
  input  logic [ADDR_W-1:0] wt_cmd_addr,
  input  logic [LEN_W-1:0]  wt_cmd_bytes,
  output logic              wt_rd_valid,
  input  logic              wt_rd_ready,
  output logic [DATA_W-1:0] wt_rd_data,
  output logic              wt_rd_last,
  output logic [ID_W-1:0]   M_AXI_ARID,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [ID_W-1:0]   M_AXI_RID,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic              M_AXI_RLAST,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,
  output logic              rid_err
);

  localparam int BB = DATA_W / 8;

  logic              dat_req, wt_req;
  logic [ADDR_W-1:0] dat_req_addr, wt_req_addr;
  logic [8:0]        dat_req_blen, wt_req_blen;
  logic              ar_hs;
  logic              rid_dat, rid_wt, rid_bad;

  ar_state_t         ar_state, ar_state_nx;
  logic              gnt_dat, gnt_wt;
  logic              ar_owner;
  logic              last_gnt;
  logic [ID_W-1:0]   ar_id;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;

  assign ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
  assign rid_dat = (M_AXI_RID == ID_W'(DAT_ID));
  assign rid_wt  = (M_AXI_RID == ID_W'(WT_ID)) && !rid_dat;
  assign rid_bad = M_AXI_RVALID && !rid_dat && !rid_wt;

  conv_rd_burst_splitter #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BB(BB), .MAX_BURST(MAX_BURST), .MAX_OUTST(MAX_OUTST)
  ) u_dat_split (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (dat_cmd_valid),
    .cmd_ready  (dat_cmd_ready),
    .cmd_addr   (dat_cmd_addr),
    .cmd_bytes  (dat_cmd_bytes),
    .req        (dat_req),
    .req_addr   (dat_req_addr),
    .req_blen   (dat_req_blen),
    .ar_fire    (ar_hs && (ar_owner == REQ_DAT)),
    .r_fire     (dat_rd_valid && dat_rd_ready),
    .r_last_fire(dat_rd_valid && dat_rd_ready && M_AXI_RLAST),
    .rd_last    (dat_rd_last)
  );

  conv_rd_burst_splitter #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BB(BB), .MAX_BURST(MAX_BURST), .MAX_OUTST(MAX_OUTST)
  ) u_wt_split (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (wt_cmd_valid),
    .cmd_ready  (wt_cmd_ready),
    .cmd_addr   (wt_cmd_addr),
    .cmd_bytes  (wt_cmd_bytes),
    .req        (wt_req),
    .req_addr   (wt_req_addr),
    .req_blen   (wt_req_blen),
    .ar_fire    (ar_hs && (ar_owner == REQ_WT)),
    .r_fire     (wt_rd_valid && wt_rd_ready),
    .r_last_fire(wt_rd_valid && wt_rd_ready && M_AXI_RLAST),
    .rd_last    (wt_rd_last)
  );

  // Round-robin at burst granularity: on a tie the port not granted last wins
  always_comb begin
    ar_state_nx = ar_state;
    gnt_dat     = 1'b0;
    gnt_wt      = 1'b0;
    case (ar_state)
      AR_IDLE: begin
        if (dat_req && (!wt_req || (last_gnt == REQ_WT))) begin
          gnt_dat     = 1'b1;
          ar_state_nx = AR_BUSY;
        end else if (wt_req) begin
          gnt_wt      = 1'b1;
          ar_state_nx = AR_BUSY;
        end
      end
      AR_BUSY: begin
        if (M_AXI_ARREADY) ar_state_nx = AR_IDLE;
      end
      default: ar_state_nx = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_state <= AR_IDLE;
      ar_id    <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_owner <= REQ_DAT;
      last_gnt <= REQ_WT;   // makes the very first tie go to dat
      rid_err  <= 1'b0;
    end else begin
      ar_state <= ar_state_nx;
      if (gnt_dat) begin
        ar_id    <= ID_W'(DAT_ID);
        ar_addr  <= dat_req_addr;
        ar_len   <= 8'(dat_req_blen - 9'd1);
        ar_owner <= REQ_DAT;
        last_gnt <= REQ_DAT;
      end else if (gnt_wt) begin
        ar_id    <= ID_W'(WT_ID);
        ar_addr  <= wt_req_addr;
        ar_len   <= 8'(wt_req_blen - 9'd1);
        ar_owner <= REQ_WT;
        last_gnt <= REQ_WT;
      end
      if (rid_bad) rid_err <= 1'b1;
    end
  end

  assign M_AXI_ARVALID = (ar_state == AR_BUSY);
  assign M_AXI_ARID    = ar_id;
  assign M_AXI_ARADDR  = ar_addr;
  assign M_AXI_ARLEN   = ar_len;
  assign M_AXI_ARSIZE  = 3'($clog2(BB));
  assign M_AXI_ARBURST = 2'b01;

  // Unknown RIDs are swallowed so a stray beat cannot stall the channel
  assign dat_rd_valid = M_AXI_RVALID && rid_dat;
  assign wt_rd_valid  = M_AXI_RVALID && rid_wt;
  assign dat_rd_data  = M_AXI_RDATA;
  assign wt_rd_data   = M_AXI_RDATA;
  assign M_AXI_RREADY = rid_dat ? dat_rd_ready : (rid_wt ? wt_rd_ready : 1'b1);

endmodule
